bus_wait_gen: RTL and testbench

- Bus-side responder that drives the 6502 READY input pin. It is the counterpart of the CPU's phi2-clocked ready sampler.
- Decodes each CPU bus cycle. It stretches reads to slow address pages either by a fixed wait-state count or by a req/ack handshake with a slow peripheral.
- Posts writes to the slow peripheral, because the CPU ignores READY while writing.
- Sits between the CPU pins and the memory/peripheral decode logic. One clk_2 edge equals one CPU cycle.

---
 rtl/bus_wait_gen.sv | 201 ++++++++++++++++++++
 tb/tb_bus_wait_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_gen.sv
// Purpose: drives the 6502 READY pin; stretches reads to slow pages and posts writes to a slow peripheral.
// Latency: registered outputs, decisions take effect one clk_2 edge after the bus is sampled.
// Backpressure: READY low stalls CPU reads; slow_req is held until slow_ack or the timeout expires.
//
// Ports:
//   clk_2       CPU phi2 clock, every state change on its rising edge
//   res_n       asynchronous active-low reset
//   addr/rw_n/dbus  CPU bus sampled each edge
//   READY       to CPU READY pin, low stalls a read cycle
//   slow_req/slow_we/slow_addr/slow_wdata  request to slow peripheral, valid while slow_req=1
//   slow_ack    peripheral completion, sampled on rising edge
//   timeout_err one-cycle pulse on handshake timeout or a dropped slow write
module bus_wait_gen #(
  parameter logic [3:0]  WAIT_PAGE   = 4'hD,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [3:0]  SLOW_PAGE   = 4'hC,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk_2,
  input  logic        res_n,
  input  logic [15:0] addr,
  input  logic        rw_n,
  input  logic [7:0]  dbus,
  output logic        READY,
  output logic        slow_req,
  output logic        slow_we,
  output logic [11:0] slow_addr,
  output logic [7:0]  slow_wdata,
  input  logic        slow_ack,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITC,
    S_RDREQ,
    S_POSTWR,
    S_HOLD
  } state_t;

  localparam bit         WAIT_EN   = (WAIT_CYCLES != 0);
  localparam logic [7:0] WAIT_LOAD = WAIT_EN ? 8'(WAIT_CYCLES - 1) : 8'd0;
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [11:0] saddr_q, saddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;

  // Bus decode of the current sample
  logic page_wait, page_slow;
  logic rd_wait, rd_slow, wr_slow;
  logic postwr_hit;
  logic tcnt_expired;
  logic [7:0] tcnt_inc;

  assign page_wait  = (addr[15:12] == WAIT_PAGE);
  assign page_slow  = (addr[15:12] == SLOW_PAGE);
  assign rd_wait    = rw_n & page_wait;
  assign rd_slow    = rw_n & page_slow;
  assign wr_slow    = ~rw_n & page_slow;
  // Accesses that cannot be serviced while a posted write is still in flight
  assign postwr_hit = rd_wait | rd_slow | wr_slow;

  assign tcnt_expired = (tcnt_q == TCNT_LAST);
  assign tcnt_inc     = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    req_d   = req_q;
    we_d    = we_q;
    saddr_d = saddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      S_IDLE: begin
        if (rd_wait && WAIT_EN) begin
          ready_d = 1'b0;
          cnt_d   = WAIT_LOAD;
          state_d = S_WAITC;
        end else if (rd_slow) begin
          ready_d = 1'b0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          saddr_d = addr[11:0];
          tcnt_d  = 8'd0;
          state_d = S_RDREQ;
        end else if (wr_slow) begin
          ready_d = 1'b1;
          req_d   = 1'b1;
          we_d    = 1'b1;
          saddr_d = addr[11:0];
          wdata_d = dbus;
          tcnt_d  = 8'd0;
          state_d = S_POSTWR;
        end else begin
          ready_d = 1'b1;
        end
      end

      S_WAITC: begin
        if (cnt_q == 8'd0) begin
          ready_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_RDREQ: begin
        // Ack wins over an expiry on the same edge
        if (slow_ack) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          state_d = S_HOLD;
        end else if (tcnt_expired) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end

      S_POSTWR: begin
        // READY is sticky-low here: a stalled read holds the bus, so IDLE
        // re-decodes the same access on the edge after the write completes.
        if (postwr_hit) begin
          ready_d = 1'b0;
        end
        // A second slow write cannot be held off by READY; it is dropped.
        if (wr_slow) begin
          err_d = 1'b1;
        end
        if (slow_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (tcnt_expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end

      // The edge after release still shows the completed address; skip it.
      S_HOLD: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      saddr_q <= 12'd0;
      wdata_q <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      we_q    <= we_d;
      saddr_q <= saddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign READY       = ready_q;
  assign slow_req    = req_q;
  assign slow_we     = we_q;
  assign slow_addr   = saddr_q;
  assign slow_wdata  = wdata_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_bus_wait_gen.sv
// Directed bench for bus_wait_gen with default parameters
// (WAIT_PAGE=D, WAIT_CYCLES=2, SLOW_PAGE=C, TIMEOUT=16).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_bus_wait_gen;

  logic        clk_2;
  logic        res_n;
  logic [15:0] addr;
  logic        rw_n;
  logic [7:0]  dbus;
  logic        READY;
  logic        slow_req;
  logic        slow_we;
  logic [11:0] slow_addr;
  logic [7:0]  slow_wdata;
  logic        slow_ack;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int low_cnt;
  int err_cnt;

  bus_wait_gen dut (
    .clk_2       (clk_2),
    .res_n       (res_n),
    .addr        (addr),
    .rw_n        (rw_n),
    .dbus        (dbus),
    .READY       (READY),
    .slow_req    (slow_req),
    .slow_we     (slow_we),
    .slow_addr   (slow_addr),
    .slow_wdata  (slow_wdata),
    .slow_ack    (slow_ack),
    .timeout_err (timeout_err)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] d);
    addr = a;
    rw_n = r;
    dbus = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n    = 1'b0;
    slow_ack = 1'b0;
    bus(16'h0200, 1'b1, 8'h00);
    repeat (2) tick();

    // Reset state
    check("rst_ready", 32'(READY), 1);
    check("rst_req",   32'(slow_req), 0);
    check("rst_we",    32'(slow_we), 0);
    check("rst_addr",  32'(slow_addr), 0);
    check("rst_wdata", 32'(slow_wdata), 0);
    check("rst_err",   32'(timeout_err), 0);

    res_n = 1'b1;
    tick();
    check("idle_ready", 32'(READY), 1);

    // Fixed wait-state read: two low cycles, high on third edge, no restall
    bus(16'hD123, 1'b1, 8'h00);
    tick();
    check("wait_e0", 32'(READY), 0);
    tick();
    check("wait_e1", 32'(READY), 0);
    tick();
    check("wait_e2", 32'(READY), 1);
    tick();
    check("wait_hold", 32'(READY), 1);
    bus(16'h0200, 1'b1, 8'h00);
    tick();
    check("wait_after", 32'(READY), 1);

    // Handshake read acked on the third edge after the request
    bus(16'hC045, 1'b1, 8'h00);
    tick();
    check("rd_ready0", 32'(READY), 0);
    check("rd_req",    32'(slow_req), 1);
    check("rd_we",     32'(slow_we), 0);
    check("rd_addr",   32'(slow_addr), 'h045);
    tick();
    tick();
    check("rd_ready2", 32'(READY), 0);
    slow_ack = 1'b1;
    tick();
    slow_ack = 1'b0;
    check("rd_ack_ready", 32'(READY), 1);
    check("rd_ack_req",   32'(slow_req), 0);
    check("rd_ack_err",   32'(timeout_err), 0);
    tick();
    check("rd_hold_ready", 32'(READY), 1);
    check("rd_hold_req",   32'(slow_req), 0);
    bus(16'h0200, 1'b1, 8'h00);
    tick();

    // Handshake read with no ack: 16 low cycles then timeout pulse
    bus(16'hC000, 1'b1, 8'h00);
    tick();
    low_cnt = (READY == 1'b0) ? 1 : 0;
    err_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (READY == 1'b0) low_cnt++;
      if (timeout_err) err_cnt++;
    end
    check("to_low_cycles", 32'(low_cnt), 16);
    check("to_early_err",  32'(err_cnt), 0);
    tick();
    check("to_ready", 32'(READY), 1);
    check("to_err",   32'(timeout_err), 1);
    check("to_req",   32'(slow_req), 0);
    tick();
    check("to_err_pulse", 32'(timeout_err), 0);
    check("to_hold_ready", 32'(READY), 1);
    bus(16'h0200, 1'b1, 8'h00);
    tick();

    // Ack on the expiry edge counts as success
    bus(16'hC000, 1'b1, 8'h00);
    tick();
    repeat (15) tick();
    check("race_ready_low", 32'(READY), 0);
    slow_ack = 1'b1;
    tick();
    slow_ack = 1'b0;
    check("race_ready", 32'(READY), 1);
    check("race_err",   32'(timeout_err), 0);
    check("race_req",   32'(slow_req), 0);
    tick();
    bus(16'h0200, 1'b1, 8'h00);
    tick();

    // Ack while idle is ignored
    slow_ack = 1'b1;
    tick();
    slow_ack = 1'b0;
    check("idle_ack_req",   32'(slow_req), 0);
    check("idle_ack_ready", 32'(READY), 1);
    check("idle_ack_err",   32'(timeout_err), 0);

    // Posted write, CPU keeps running on unrelated reads
    bus(16'hC010, 1'b0, 8'h5A);
    tick();
    check("pw_req",   32'(slow_req), 1);
    check("pw_we",    32'(slow_we), 1);
    check("pw_addr",  32'(slow_addr), 'h010);
    check("pw_wdata", 32'(slow_wdata), 'h5A);
    check("pw_ready", 32'(READY), 1);
    bus(16'h0200, 1'b1, 8'h00);
    low_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (READY == 1'b0) low_cnt++;
    end
    check("pw_ready_free", 32'(low_cnt), 0);
    check("pw_we_held",    32'(slow_we), 1);
    check("pw_wdata_held", 32'(slow_wdata), 'h5A);
    slow_ack = 1'b1;
    tick();
    slow_ack = 1'b0;
    check("pw_ack_req",   32'(slow_req), 0);
    check("pw_ack_ready", 32'(READY), 1);
    tick();
    check("pw_idle_ready", 32'(READY), 1);

    // Posted write followed by a wait-page read before the ack
    bus(16'hC010, 1'b0, 8'h33);
    tick();
    check("pwr_e0_ready", 32'(READY), 1);
    bus(16'hD000, 1'b1, 8'h00);
    tick();
    check("pwr_e1_ready", 32'(READY), 0);
    slow_ack = 1'b1;
    tick();
    slow_ack = 1'b0;
    check("pwr_e2_ready", 32'(READY), 0);
    check("pwr_e2_req",   32'(slow_req), 0);
    tick();
    check("pwr_e3_ready", 32'(READY), 0);
    tick();
    check("pwr_e4_ready", 32'(READY), 0);
    tick();
    check("pwr_e5_ready", 32'(READY), 1);
    tick();
    check("pwr_hold_ready", 32'(READY), 1);
    bus(16'h0200, 1'b1, 8'h00);
    tick();

    // Back-to-back slow writes: the second one is dropped and flagged
    bus(16'hC010, 1'b0, 8'h11);
    tick();
    bus(16'hC020, 1'b0, 8'h22);
    tick();
    check("lost_err",   32'(timeout_err), 1);
    check("lost_wdata", 32'(slow_wdata), 'h11);
    bus(16'h0200, 1'b1, 8'h00);
    tick();
    check("lost_err_pulse", 32'(timeout_err), 0);
    check("lost_req_held",  32'(slow_req), 1);
    slow_ack = 1'b1;
    tick();
    slow_ack = 1'b0;
    check("lost_ack_req", 32'(slow_req), 0);
    tick();
    check("lost_release", 32'(READY), 1);

    // Reset during a handshake read drops everything immediately
    bus(16'hC045, 1'b1, 8'h00);
    tick();
    check("mid_req", 32'(slow_req), 1);
    #2;
    res_n = 1'b0;
    #1;
    check("arst_ready", 32'(READY), 1);
    check("arst_req",   32'(slow_req), 0);
    check("arst_addr",  32'(slow_addr), 0);
    tick();
    res_n = 1'b1;
    bus(16'h0200, 1'b1, 8'h00);
    slow_ack = 1'b1;
    tick();
    slow_ack = 1'b0;
    check("post_rst_ack_req",   32'(slow_req), 0);
    check("post_rst_ack_ready", 32'(READY), 1);
    check("post_rst_ack_err",   32'(timeout_err), 0);
    bus(16'hD123, 1'b1, 8'h00);
    tick();
    check("restart_e0", 32'(READY), 0);
    tick();
    check("restart_e1", 32'(READY), 0);
    tick();
    check("restart_e2", 32'(READY), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
